// File: rtl/water_pkg.sv
// rtl/water_pkg.sv - shared types, segment patterns and helpers for water_level_ctrl
package water_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILLING = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    // gfedcba patterns, active high
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;
    localparam logic [6:0] SEG_LETTER_E = 7'b1111001;

    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        case (d)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

    // A thermometer code is 2^k - 1: adding one clears every set bit.
    function automatic logic is_thermo(input logic [15:0] v);
        return ((v + 16'd1) & v) == 16'd0;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - single-bit debouncer accepting a change after DEB_CYCLES stable edges
module sensor_debounce #(
    parameter int DEB_CYCLES = 3
) (
    input  logic clk_2,
    input  logic reset,
    input  logic raw,
    output logic deb,
    output logic deb_next
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [7:0] cnt;
    logic [7:0] cnt_next;

    // deb_next lets the parent see a level change on the same edge it is accepted
    always_comb begin
        deb_next = deb;
        cnt_next = 8'd0;
        if (raw != deb) begin
            if (cnt == DEB_LAST) begin
                deb_next = raw;
            end else begin
                cnt_next = cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            deb <= 1'b0;
            cnt <= 8'd0;
        end else begin
            deb <= deb_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/water_level_ctrl.sv
// rtl/water_level_ctrl.sv - debounced tank level, fill pump FSM with timeout and seven-segment display
module water_level_ctrl
    import water_pkg::*;
#(
    parameter int NSENS        = 4,
    parameter int DEB_CYCLES   = 3,
    parameter int FILL_TIMEOUT = 15,
    parameter int LOW_MARK     = 1
) (
    input  logic                       clk_2,
    input  logic                       reset,
    input  logic [NSENS-1:0]           sensor,
    input  logic                       clr,
    output logic [$clog2(NSENS+1)-1:0] level,
    output logic                       pump,
    output logic                       fault,
    output logic [7:0]                 SEG
);

    localparam int LW = $clog2(NSENS + 1);
    localparam logic [15:0] TMO_LAST = 16'(FILL_TIMEOUT - 1);

    logic [NSENS-1:0] deb_vec;
    logic [NSENS-1:0] deb_vec_next;
    logic [LW-1:0]    level_next;
    logic             valid;
    logic             level_up;
    logic             timeout;
    logic [15:0]      tcnt;
    state_t           state;

    for (genvar i = 0; i < NSENS; i++) begin : g_deb
        sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_2    (clk_2),
            .reset    (reset),
            .raw      (sensor[i]),
            .deb      (deb_vec[i]),
            .deb_next (deb_vec_next[i])
        );
    end

    always_comb begin
        level      = '0;
        level_next = '0;
        for (int i = 0; i < NSENS; i++) begin
            level      = level + LW'(deb_vec[i]);
            level_next = level_next + LW'(deb_vec_next[i]);
        end
    end

    assign valid    = is_thermo(16'(deb_vec));
    assign level_up = level_next > level;
    assign timeout  = !level_up && (tcnt == TMO_LAST);

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            tcnt  <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!valid) begin
                        state <= ST_FAULT;
                    end else if (level <= LW'(LOW_MARK)) begin
                        state <= ST_FILLING;
                        tcnt  <= 16'd0;
                    end
                end
                ST_FILLING: begin
                    if (!valid || timeout) begin
                        state <= ST_FAULT;
                    end else if (level == LW'(NSENS)) begin
                        state <= ST_IDLE;
                    end else begin
                        // a falling level keeps counting so a leak cannot stall the timeout
                        tcnt <= level_up ? 16'd0 : tcnt + 16'd1;
                    end
                end
                ST_FAULT: begin
                    if (clr && valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pump  = (state == ST_FILLING);
    assign fault = (state == ST_FAULT);
    assign SEG   = {pump, fault ? SEG_LETTER_E : hex_seg(4'(level))};

endmodule

// File: tb/tb_water_level_ctrl.sv
// tb/tb_water_level_ctrl.sv - table-driven directed bench for water_level_ctrl
module tb_water_level_ctrl;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [3:0] sensor;
    logic       clr;
    logic [2:0] level;
    logic       pump;
    logic       fault;
    logic [7:0] SEG;

    int n_vec  = 0;
    int n_fail = 0;

    water_level_ctrl dut (
        .clk_2  (clk_2),
        .reset  (reset),
        .sensor (sensor),
        .clr    (clr),
        .level  (level),
        .pump   (pump),
        .fault  (fault),
        .SEG    (SEG)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic [3:0] sensor;
        logic       clr;
        int         edges;
        logic [2:0] exp_level;
        logic       exp_pump;
        logic       exp_fault;
        logic [7:0] exp_seg;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [2:0] el, input logic ep,
                         input logic ef, input logic [7:0] es);
        n_vec++;
        if (level !== el || pump !== ep || fault !== ef || SEG !== es) begin
            n_fail++;
            $display("FAIL %s: got level=%0d pump=%b fault=%b SEG=%b, want level=%0d pump=%b fault=%b SEG=%b",
                     name, level, pump, fault, SEG, el, ep, ef, es);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic add(input logic [3:0] s, input logic c, input int n, input logic [2:0] el,
                       input logic ep, input logic ef, input logic [7:0] es);
        vec_t v;
        v.sensor = s; v.clr = c; v.edges = n;
        v.exp_level = el; v.exp_pump = ep; v.exp_fault = ef; v.exp_seg = es;
        tbl.push_back(v);
    endtask

    initial begin
        // power-on, glitch rejection, acceptance, fill cycle with hysteresis
        add(4'b0000, 0, 1,  3'd0, 1, 0, 8'b1_0111111);
        add(4'b0001, 0, 2,  3'd0, 1, 0, 8'b1_0111111);
        add(4'b0000, 0, 3,  3'd0, 1, 0, 8'b1_0111111);
        add(4'b0001, 0, 2,  3'd0, 1, 0, 8'b1_0111111);
        add(4'b0001, 0, 1,  3'd1, 1, 0, 8'b1_0000110);
        add(4'b0011, 0, 5,  3'd2, 1, 0, 8'b1_1011011);
        add(4'b0111, 0, 5,  3'd3, 1, 0, 8'b1_1001111);
        add(4'b1111, 0, 3,  3'd4, 1, 0, 8'b1_1100110);
        add(4'b1111, 0, 1,  3'd4, 0, 0, 8'b0_1100110);
        add(4'b1111, 0, 1,  3'd4, 0, 0, 8'b0_1100110);
        add(4'b0111, 0, 5,  3'd3, 0, 0, 8'b0_1001111);
        add(4'b0001, 0, 3,  3'd1, 0, 0, 8'b0_0000110);
        add(4'b0001, 0, 1,  3'd1, 1, 0, 8'b1_0000110);
        // level frozen at 1: 14 edges still filling, 15th edge faults
        add(4'b0001, 0, 14, 3'd1, 1, 0, 8'b1_0000110);
        add(4'b0001, 0, 1,  3'd1, 0, 1, 8'b0_1111001);
        add(4'b0001, 1, 1,  3'd1, 0, 0, 8'b0_0000110);
        add(4'b0001, 0, 1,  3'd1, 1, 0, 8'b1_0000110);
        // inconsistent vector, clr ignored while invalid
        add(4'b0101, 0, 3,  3'd2, 1, 0, 8'b1_1011011);
        add(4'b0101, 0, 1,  3'd2, 0, 1, 8'b0_1111001);
        add(4'b0101, 1, 2,  3'd2, 0, 1, 8'b0_1111001);
        add(4'b1111, 1, 3,  3'd4, 0, 1, 8'b0_1111001);
        add(4'b1111, 1, 1,  3'd4, 0, 0, 8'b0_1100110);
        add(4'b1111, 0, 2,  3'd4, 0, 0, 8'b0_1100110);

        reset = 1'b1; sensor = 4'b0000; clr = 1'b0;
        #12;
        check("reset_values", 3'd0, 0, 0, 8'b0_0111111);
        @(negedge clk_2);
        reset = 1'b0;
        #1;

        foreach (tbl[i]) begin
            sensor = tbl[i].sensor;
            clr    = tbl[i].clr;
            step(tbl[i].edges);
            check($sformatf("vec%0d", i), tbl[i].exp_level, tbl[i].exp_pump,
                  tbl[i].exp_fault, tbl[i].exp_seg);
        end

        // async reset in FILLING, no clock edge in between
        sensor = 4'b0000; clr = 1'b0;
        step(4);
        check("refill_low", 3'd0, 1, 0, 8'b1_0111111);
        #2 reset = 1'b1;
        #1 check("async_reset_filling", 3'd0, 0, 0, 8'b0_0111111);
        #1 reset = 1'b0;
        step(1);
        check("first_edge_after_reset", 3'd0, 1, 0, 8'b1_0111111);

        // async reset in FAULT
        sensor = 4'b0010;
        step(4);
        check("fault_on_bit1_only", 3'd1, 0, 1, 8'b0_1111001);
        #2 reset = 1'b1;
        #1 check("async_reset_fault", 3'd0, 0, 0, 8'b0_0111111);
        #1 reset = 1'b0;
        sensor = 4'b0000;
        step(1);
        check("no_fault_retained", 3'd0, 1, 0, 8'b1_0111111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/water_level_ctrl.md
WATER_LEVEL_CTRL -- requirements
Module: water_level_ctrl

Interface
REQ-001 Parameter NSENS, default 4: number of level sensors, legal range 2..15; bit 0 is the lowest sensor.
REQ-002 Parameter DEB_CYCLES, default 3: consecutive stable cycles required before a sensor bit is accepted, legal range 1..255.
REQ-003 Parameter FILL_TIMEOUT, default 15: maximum cycles in FILLING without a level increase, legal range 1..65535.
REQ-004 Parameter LOW_MARK, default 1: level at or below which filling starts; 0 <= LOW_MARK < NSENS.
REQ-005 Clock and reset: one clock, clk_2; asynchronous, active-high reset, reset.
REQ-006 clk_2  input  1  system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 sensor  input  NSENS  raw level sensors; 1 = water present.
REQ-009 clr  input  1  fault acknowledge, sampled on clk_2.
REQ-010 level  output  $clog2(NSENS+1)  accepted water level: count of ones in the debounced vector.
REQ-011 pump  output  1  pump enable; high only in FILLING.
REQ-012 fault  output  1  high only in FAULT.
REQ-013 SEG  output  8  seven-segment pattern; bits 6:0 = gfedcba, bit 7 = pump.

Function
REQ-014 Per sensor bit: raw is compared each cycle with the debounced value; a per-bit counter increments while they differ, and clears when they are equal.
REQ-015 The debounced bit takes the raw value on the edge where the counter reaches DEB_CYCLES, and the counter clears on that edge.
REQ-016 Result: a change held for DEB_CYCLES edges appears on level after the DEB_CYCLES-th edge; a glitch shorter than that never appears.
REQ-017 The debounced vector is valid only as a thermometer code, i.e. ones contiguous from bit 0 (0000, 0001, 0011, 0111, 1111 for NSENS=4).
REQ-018 Any invalid vector is a sensor inconsistency.
REQ-019 FSM states: IDLE, FILLING, FAULT; next state is registered, and pump/fault decode combinationally from the state register.
REQ-020 Transitions out of IDLE: to FAULT on an invalid vector; else to FILLING when level <= LOW_MARK; else stay.
REQ-021 Transitions out of FILLING: to FAULT on an invalid vector or on timeout; else to IDLE when level == NSENS; else stay.
REQ-022 Transitions out of FAULT: to IDLE when clr = 1 and the vector is valid; else stay.
REQ-023 Invalid-vector priority: an invalid vector forces FAULT regardless of every other condition, including clr in the same cycle.
REQ-024 Timeout counter: 16 bits; cleared on entry to FILLING and on every cycle where level increases; otherwise increments in FILLING.
REQ-025 Timeout fires when the counter reaches FILL_TIMEOUT.
REQ-026 A level decrease during FILLING does not clear the timeout counter.
REQ-027 SEG[6:0] in FAULT shows letter E (1111001).
REQ-028 SEG[6:0] in any other state shows level as a hex digit 0..F using standard gfedcba encoding, e.g. 0 = 0111111, 4 = 1100110.
REQ-029 Hysteresis: after reaching full, the pump does not restart until level <= LOW_MARK.

Reset
REQ-030 On reset assertion: state = IDLE, debounced vector = 0, all debounce counters = 0, timeout counter = 0, independent of clk_2.
REQ-031 Output values during reset: level = 0, pump = 0, fault = 0, SEG = 0111111.
REQ-032 First edge after reset release: because level 0 <= LOW_MARK, the FSM enters FILLING on that edge.
REQ-033 Reset asserted mid-FILLING or mid-FAULT aborts immediately to the reset values; no fault state is retained.

Structure
REQ-034 Package water_pkg holds the state enum, the segment constants (digits 0..F and letter E), and a thermometer-check function.
REQ-035 Sub-module sensor_debounce (one bit, parameter DEB_CYCLES) is instantiated NSENS times via generate.

Verification
REQ-036 Defaults apply unless noted; "edges" counts clk_2 rising edges.
REQ-037 Reset then sensor = 0000: after the first edge, pump = 1 and SEG = 10111111 (pump bit plus digit 0).
REQ-038 Debounce: sensor goes 0000 -> 0001 for 2 edges then back to 0000 -> level stays 0; 0001 held for 3 edges -> level = 1 on edge 3.
REQ-039 Fill cycle: step sensor 0001, 0011, 0111, 1111, each held 5 edges -> pump drops on the edge after level = 4; then 0111 -> pump stays 0; then 0001 -> pump = 1.
REQ-040 Timeout: FILLING with level frozen at 1 -> fault = 1 and SEG[6:0] = 1111001 on the 15th edge without an increase.
REQ-041 Inconsistency: sensor 0101 held 3 edges -> FAULT; clr = 1 while still 0101 -> stays FAULT; sensor 1111 valid plus clr -> IDLE.
REQ-042 Asynchronous reset pulse mid-FILLING between edges -> pump = 0 and level = 0 immediately, without waiting for an edge.
